// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered ALU operands, one registered response slot.
//
// Handshake rules, for both the request ports and the response channel:
//   a transfer happens on a rising edge where valid and ready are both high.
//   Requesters hold valid and operands stable until ready. Once rsp_valid
//   rises, every rsp_* output is held until rsp_ready is seen. reqN_ready
//   is a combinational function of state and the valids, and is low during reset.
module alu_arbiter #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // port 0: integer issue
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [REG_WIDTH-1:0]     req0_rs1,
  input  logic [REG_WIDTH-1:0]     req0_rs2,
  input  logic [REG_WIDTH-1:0]     req0_imm,
  input  logic [ALU_CTRL_BITS-1:0] req0_ctrl,
  // port 1: branch/address unit
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [REG_WIDTH-1:0]     req1_rs1,
  input  logic [REG_WIDTH-1:0]     req1_rs2,
  input  logic [REG_WIDTH-1:0]     req1_imm,
  input  logic [ALU_CTRL_BITS-1:0] req1_ctrl,
  // shared ALU
  output logic [REG_WIDTH-1:0]     alu_rs1,
  output logic [REG_WIDTH-1:0]     alu_rs2,
  output logic [REG_WIDTH-1:0]     alu_imm,
  output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
  input  logic [REG_WIDTH-1:0]     alu_out,
  input  logic                     alu_zero,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [REG_WIDTH-1:0]     rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic                     rsp_id,
  // debug view of the FSM state
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  // last_grant_q also serves as the id of the transaction in flight
  logic                     last_grant_q, last_grant_d;
  logic [REG_WIDTH-1:0]     alu_rs1_q, alu_rs1_d;
  logic [REG_WIDTH-1:0]     alu_rs2_q, alu_rs2_d;
  logic [REG_WIDTH-1:0]     alu_imm_q, alu_imm_d;
  logic [ALU_CTRL_BITS-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [REG_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                     rsp_zero_q, rsp_zero_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     rsp_id_q, rsp_id_d;
  logic                     grant_id;
  logic                     ctrl_ok;

  // Legal codes are 0-9, 16 and 18-25; anything else is reported as an error.
  function automatic logic ctrl_legal(input logic [ALU_CTRL_BITS-1:0] c);
    int unsigned v;
    v = 32'(c);
    return (v <= 32'd9) || (v == 32'd16) || ((v >= 32'd18) && (v <= 32'd25));
  endfunction

  assign ctrl_ok = ctrl_legal(alu_ctrl_q);

  // Next-state, grant and register-update logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    alu_imm_d    = alu_imm_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // With both ports valid the port that did not win last time goes next.
    grant_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          last_grant_d = grant_id;
          alu_rs1_d    = grant_id ? req1_rs1  : req0_rs1;
          alu_rs2_d    = grant_id ? req1_rs2  : req0_rs2;
          alu_imm_d    = grant_id ? req1_imm  : req0_imm;
          alu_ctrl_d   = grant_id ? req1_ctrl : req0_ctrl;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // An illegal code masks the ALU result so nothing undefined leaks out.
        rsp_data_d = ctrl_ok ? alu_out : '0;
        rsp_zero_d = ctrl_ok ? alu_zero : 1'b0;
        rsp_err_d  = ~ctrl_ok;
        rsp_id_d   = last_grant_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst_n) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      alu_imm_q    <= '0;
      alu_ctrl_q   <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      alu_imm_q    <= alu_imm_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_rs1   = alu_rs1_q;
  assign alu_rs2   = alu_rs2_q;
  assign alu_imm   = alu_imm_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rst_n && (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, a round-robin reference model that
// predicts grants and pushes expected responses, and a separate monitor
// that checks the response channel against the expected queue.
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int CB = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_rs1, req0_rs2, req0_imm, req1_rs1, req1_rs2, req1_imm;
  logic [CB-1:0] req0_ctrl, req1_ctrl;
  logic [W-1:0]  alu_rs1, alu_rs2, alu_imm, alu_out, rsp_data;
  logic [CB-1:0] alu_ctrl;
  logic          alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_err, rsp_id;
  logic [1:0]    dbg_state;

  alu_arbiter #(.REG_WIDTH(W), .ALU_CTRL_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_ctrl(req1_ctrl),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_id(rsp_id), .dbg_state(dbg_state)
  );

  // stand-in ALU (produces a non-zero value for illegal codes on purpose)
  function automatic logic [W-1:0] alu_ref(input logic [CB-1:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] i);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a + i;
      5'd6:    return a << b[5:0];
      5'd7:    return a >> b[5:0];
      default: return a ^ ~b ^ i ^ 64'(c);
    endcase
  endfunction
  assign alu_out  = alu_ref(alu_ctrl, alu_rs1, alu_rs2, alu_imm);
  assign alu_zero = (alu_rs1 == alu_rs2);

  // scoreboard
  typedef struct {
    logic [W-1:0]  data;
    logic          zero;
    logic          err;
    logic          id;
    logic [CB-1:0] ctrl;
    logic [W-1:0]  rs1;
    int unsigned   acc;
  } exp_t;
  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model: who may be granted, and what the response must be
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  int unsigned m_acc  = 0;

  always @(negedge clk) begin : issue_model
    logic g, e0, e1, legal;
    logic [CB-1:0] c;
    logic [W-1:0] r1, r2, im;
    exp_t e;
    if (!rst_n) begin
      chk("reset_ready", 64'({req1_ready, req0_ready}), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      m_busy = 1'b0;
      m_last = 1'b1;
      exp_q.delete();
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      g  = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) g = !m_last;
        else g = req1_valid;
        e0 = !g;
        e1 = g;
      end
      chk("grant", 64'({req1_ready, req0_ready}), 64'({e1, e0}));
      if (e0 || e1) begin
        c  = g ? req1_ctrl : req0_ctrl;
        r1 = g ? req1_rs1 : req0_rs1;
        r2 = g ? req1_rs2 : req0_rs2;
        im = g ? req1_imm : req0_imm;
        legal = (c inside {[5'd0:5'd9], 5'd16, [5'd18:5'd25]});
        e.data = legal ? alu_ref(c, r1, r2, im) : '0;
        e.zero = legal ? (r1 == r2) : 1'b0;
        e.err  = !legal;
        e.id   = g;
        e.ctrl = c;
        e.rs1  = r1;
        e.acc  = cyc;
        exp_q.push_back(e);
        m_busy = 1'b1;
        m_last = g;
        m_acc  = cyc;
      end else if (m_busy && (cyc >= m_acc + 2) && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // monitor: response timing, content and stability while stalled
  always @(negedge clk) begin : monitor
    logic ev;
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      end else begin
        ev = (cyc >= exp_q[0].acc + 2);
        chk("rsp_valid_timing", 64'(rsp_valid), 64'(ev));
        if (ev) begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_zero", 64'(rsp_zero), 64'(exp_q[0].zero));
          chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
          chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
          chk("alu_ctrl_held", 64'(alu_ctrl), 64'(exp_q[0].ctrl));
          chk("alu_rs1_held", alu_rs1, exp_q[0].rs1);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  logic a0, a1;

  task automatic step();
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [CB-1:0] c,
                          input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] im);
    if (p == 0) begin
      req0_valid = v; req0_ctrl = c; req0_rs1 = r1; req0_rs2 = r2; req0_imm = im;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_rs1 = r1; req1_rs2 = r2; req1_imm = im;
    end
  endtask

  task automatic rand_op(input int p);
    logic [W-1:0] r1, r2;
    r1 = {$urandom, $urandom};
    r2 = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
    set_port(p, 1'b1, CB'($urandom_range(0, 31)), r1, r2, {$urandom, $urandom});
  endtask

  task automatic issue(input int p, input logic [CB-1:0] c, input logic [W-1:0] r1,
                       input logic [W-1:0] r2, input logic [W-1:0] im);
    logic got;
    got = 1'b0;
    set_port(p, 1'b1, c, r1, r2, im);
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = (p == 0) ? a0 : a1;
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
    if (p == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && m_busy; k++) step();
    if (m_busy) chk("idle_timeout", 64'(m_busy), 64'(0));
  endtask

  initial begin
    int cnt0, cnt1;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_port(0, 1'b0, '0, '0, '0, '0);
    set_port(1, 1'b0, '0, '0, '0, '0);
    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_alu_rs1", alu_rs1, 64'(0));
    chk("reset_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("reset_rsp_data", rsp_data, 64'(0));
    chk("reset_rsp_flags", 64'({rsp_zero, rsp_err, rsp_id}), 64'(0));

    // add on port 0
    issue(0, 5'd0, 64'd5, 64'd7, 64'd0);
    wait_idle();
    chk("alu_rs2_kept", alu_rs2, 64'd7);
    // sub with equal operands on port 1
    issue(1, 5'd1, 64'h55, 64'h55, 64'd0);
    wait_idle();
    // illegal code 17
    issue(0, 5'd17, 64'd3, 64'd0, 64'd4);
    wait_idle();
    chk("alu_ctrl_illegal_kept", 64'(alu_ctrl), 64'd17);
    // boundary codes
    issue(1, 5'd9, 64'd1, 64'd2, 64'd3);  wait_idle();
    issue(0, 5'd10, 64'd1, 64'd2, 64'd3); wait_idle();
    issue(1, 5'd25, 64'd4, 64'd4, 64'd3); wait_idle();
    issue(0, 5'd26, 64'd4, 64'd4, 64'd3); wait_idle();
    // response stall for 4 cycles
    rsp_ready = 1'b0;
    issue(0, 5'd4, 64'hf0f0, 64'h0ff0, 64'd0);
    repeat (5) step();
    rsp_ready = 1'b1;
    wait_idle();

    // reset in EXEC drops the op; round-robin restarts at port 0
    issue(1, 5'd2, 64'hff, 64'h0f, 64'd0);
    rst_n = 1'b0;
    rand_op(0);
    rand_op(1);
    step();
    rst_n = 1'b1;
    chk("reset_drop_rsp_valid", 64'(rsp_valid), 64'(0));
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) chk("first_grant_port0", 64'({a1, a0}), 64'(1));
      if (a0) begin cnt0++; rand_op(0); end
      if (a1) begin cnt1++; rand_op(1); end
    end
    chk("contended_grants0", 64'(cnt0), 64'(5));
    chk("contended_grants1", 64'(cnt1), 64'(5));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // random traffic with random back-pressure
    for (int i = 0; i < 800; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) rand_op(0);
      if (!req1_valid && $urandom_range(0, 2) != 0) rand_op(1);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    step();
    chk("drain_queue", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
